axi4l_reg_slave: RTL and testbench
==================================

Name: axi4l_reg_slave

Overview:
AXI4-Lite responder (slave) fronting a bank of NUM_REGS read/write registers. It is the completion end of axi4l_if transactions: it accepts AW/W beats independently, commits byte-strobed writes, and returns B and R responses. It sits behind the interconnect and exposes register contents and per-register write strobes to core logic.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, AXI data width; must be 32 or 64.
NUM_REGS, 16, number of registers; must be at least 1.
RESET_VAL, '0, reset value applied to every register, DATA_WIDTH bits.

Ports:
aclk  in  1  bus clock; all logic is on the rising edge.
aresetn  in  1  asynchronous active-low reset.
awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel.
wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
araddr/arprot/arvalid/arready  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel.
rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
reg_q  out  NUM_REGS*DATA_WIDTH  register contents; register i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
reg_wr  out  NUM_REGS  one-cycle pulse per register, high in the cycle after its contents change.

Behaviour:
- Reset, asynchronous on aresetn low: awready=wready=arready=0; bvalid=rvalid=0; bresp=rresp=OKAY; rdata=0; reg_wr=0; all registers=RESET_VAL; both holding flags cleared. The ready signals go high on the first edge after reset is released.
- Address decode: ADDR_LSB=log2(DATA_WIDTH/8). The low ADDR_LSB bits are ignored, so unaligned addresses fold down to the word. Index = addr>>ADDR_LSB. An index >= NUM_REGS gives DECERR. awprot/arprot are ignored.
- Write path, with holding flags aw_full and w_full:
  - awready = !aw_full && !bvalid.
  - wready = !w_full && !bvalid.
  - An AW handshake latches the address and sets aw_full. A W handshake latches wdata/wstrb and sets w_full.
  - AW and W may arrive in either order or in the same cycle.
  - Commit happens at the edge where both are present, counting held or same-cycle handshake values. For each strobe bit k=1, byte k of the register is updated. wstrb=0 writes nothing and still returns OKAY.
  - bvalid rises on the commit edge. bresp is OKAY, or DECERR with no register change. reg_wr[idx] pulses for one cycle only if at least one strobe bit was set.
  - bvalid holds until bready. On the B handshake, aw_full, w_full and bvalid clear together, and readiness returns the next cycle.
  - Minimum latency: AW+W in cycle T, bvalid in cycle T+1.
- Read path:
  - arready = !rvalid.
  - An AR handshake in cycle T loads rdata/rresp at that edge; rvalid is high from T+1 and holds, with stable data, until rready.
  - A DECERR read returns rdata=0.
  - Back-to-back reads sustain one transaction per 2 cycles. arready stays low while rvalid is high, including the R handshake cycle.
- Simultaneous events:
  - The read and write paths are independent.
  - A read sampled on the same edge as a write commit to the same register returns the pre-write value.
- Outputs hold stable while valid && !ready. No combinational path from any *valid input to any *ready output.
- Reset asserted mid-transaction aborts it: held beats are discarded, no partial write occurs, and valids drop asynchronously.

Decomposition:
- axi4l_pkg:
  - axi4l_resp_t (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), already used by axi4l_if.
  - Function addr_lsb(data_width).
  - Function apply_strb(old, new, strb) returning a byte-merged word.
- One sub-module, axi4l_wr_capture: holds the AW/W flags and latches, and emits a commit strobe with address, data and strb. The top level contains the register array, the read path and the B response.

Test Plan:
- Reset, then read index 3 (addr 0x0C) -> rdata=RESET_VAL, rresp=OKAY, rvalid exactly one cycle after the AR handshake.
- AW 0x08 two cycles before W 0xDEADBEEF, wstrb 4'b1111 -> bvalid one cycle after W, bresp=OKAY, reg_q[2]=0xDEADBEEF, reg_wr[2] pulses once; read back matches.
- Same-cycle AW 0x04 and W 0x11223344, wstrb 4'b0101 over a prior 0xAAAAAAAA -> reg_q[1]=0xAA22AA44, bvalid in T+1.
- Write and read to addr 0x40 with NUM_REGS=16 -> bresp=DECERR, rresp=DECERR, rdata=0, no reg_q or reg_wr change.
- Hold bready=0 for 5 cycles after a write -> bvalid and bresp stable, awready=wready=0 throughout; a second AW is accepted only the cycle after the B handshake.
- Read issued while a write to the same register commits on the same edge -> old value returned; next read returns the new value. Assert aresetn mid-write with W held -> register unchanged, all valids 0.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types and helpers: response codes, address alignment and byte-strobe merge.
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4l_resp_t;

  // Number of low address bits that select a byte within one data word.
  function automatic int unsigned addr_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Operates on the widest supported word; narrower callers zero-extend and truncate.
  function automatic logic [63:0] apply_strb(input logic [63:0] old_data,
                                             input logic [63:0] new_data,
                                             input logic [7:0]  strb);
    logic [63:0] merged;
    merged = old_data;
    for (int k = 0; k < 8; k++) begin
      if (strb[k]) merged[k*8 +: 8] = new_data[k*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4l_wr_capture.sv
// Collects AW and W beats in either order and raises a commit strobe once both are present.
module axi4l_wr_capture
  import axi4l_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   aclk_i,
  input  logic                   aresetn_i,
  input  logic                   en_i,
  input  logic [AddrWidth-1:0]   awaddr_i,
  input  logic                   awvalid_i,
  output logic                   awready_o,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] wstrb_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  input  logic                   bvalid_i,
  input  logic                   bready_i,
  output logic                   commit_o,
  output logic [AddrWidth-1:0]   cmt_addr_o,
  output logic [DataWidth-1:0]   cmt_data_o,
  output logic [DataWidth/8-1:0] cmt_strb_o
);

  logic                   aw_full_q, aw_full_d;
  logic                   w_full_q, w_full_d;
  logic [AddrWidth-1:0]   awaddr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [DataWidth/8-1:0] wstrb_q;
  logic                   aw_hs, w_hs, b_hs;

  assign awready_o = en_i && !aw_full_q && !bvalid_i;
  assign wready_o  = en_i && !w_full_q && !bvalid_i;

  assign aw_hs = awvalid_i && awready_o;
  assign w_hs  = wvalid_i && wready_o;
  assign b_hs  = bvalid_i && bready_i;

  // Flags stay set through the B phase so a new beat cannot slip in before the handshake.
  assign commit_o   = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !bvalid_i;
  assign cmt_addr_o = aw_full_q ? awaddr_q : awaddr_i;
  assign cmt_data_o = w_full_q ? wdata_q : wdata_i;
  assign cmt_strb_o = w_full_q ? wstrb_q : wstrb_i;

  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    if (b_hs) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (aw_hs) aw_full_d = 1'b1;
      if (w_hs)  w_full_d  = 1'b1;
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      if (aw_hs) awaddr_q <= awaddr_i;
      if (w_hs) begin
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
      end
    end
  end

endmodule

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite register bank responder: byte-strobed writes, B/R responses, register taps for core logic.
module axi4l_reg_slave
  import axi4l_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic                           aclk_i,
  input  logic                           aresetn_i,
  input  logic [ADDR_WIDTH-1:0]          awaddr_i,
  input  logic [2:0]                     awprot_i,
  input  logic                           awvalid_i,
  output logic                           awready_o,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic                           wvalid_i,
  output logic                           wready_o,
  output logic [1:0]                     bresp_o,
  output logic                           bvalid_o,
  input  logic                           bready_i,
  input  logic [ADDR_WIDTH-1:0]          araddr_i,
  input  logic [2:0]                     arprot_i,
  input  logic                           arvalid_i,
  output logic                           arready_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [1:0]                     rresp_o,
  output logic                           rvalid_o,
  input  logic                           rready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]            reg_wr_o
);

  localparam int unsigned StrbW  = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = addr_lsb(DATA_WIDTH);

  logic                  en_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   reg_wr_q, reg_wr_d;
  logic                  bvalid_q, rvalid_q;
  axi4l_resp_t           bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  commit;
  logic [ADDR_WIDTH-1:0] cmt_addr, wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] cmt_data, rd_word;
  logic [StrbW-1:0]      cmt_strb;
  logic                  wr_decerr, rd_decerr, ar_hs;
  logic [63:0]           merged;
  logic                  unused_prot;

  assign unused_prot = ^{awprot_i, arprot_i};

  axi4l_wr_capture #(
    .AddrWidth(ADDR_WIDTH),
    .DataWidth(DATA_WIDTH)
  ) u_wr_capture (
    .aclk_i    (aclk_i),
    .aresetn_i (aresetn_i),
    .en_i      (en_q),
    .awaddr_i  (awaddr_i),
    .awvalid_i (awvalid_i),
    .awready_o (awready_o),
    .wdata_i   (wdata_i),
    .wstrb_i   (wstrb_i),
    .wvalid_i  (wvalid_i),
    .wready_o  (wready_o),
    .bvalid_i  (bvalid_q),
    .bready_i  (bready_i),
    .commit_o  (commit),
    .cmt_addr_o(cmt_addr),
    .cmt_data_o(cmt_data),
    .cmt_strb_o(cmt_strb)
  );

  assign wr_idx    = cmt_addr >> AddrLsb;
  assign rd_idx    = araddr_i >> AddrLsb;
  assign wr_decerr = wr_idx >= ADDR_WIDTH'(NUM_REGS);
  assign rd_decerr = rd_idx >= ADDR_WIDTH'(NUM_REGS);

  assign arready_o = en_q && !rvalid_q;
  assign ar_hs     = arvalid_i && arready_o;

  always_comb begin
    merged   = '0;
    reg_wr_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      // An all-zero strobe still completes with OKAY but touches nothing.
      if (commit && (wr_idx == ADDR_WIDTH'(i)) && (|cmt_strb)) begin
        merged      = apply_strb(64'(regs_q[i]), 64'(cmt_data), 8'(cmt_strb));
        regs_d[i]   = merged[DATA_WIDTH-1:0];
        reg_wr_d[i] = 1'b1;
      end
    end
  end

  // Reads sample the pre-commit array, so a same-edge write is not visible yet.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == ADDR_WIDTH'(i)) rd_word = regs_q[i];
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      en_q     <= 1'b0;
      reg_wr_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      en_q     <= 1'b1;
      reg_wr_q <= reg_wr_d;
      regs_q   <= regs_d;
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_decerr ? DECERR : OKAY;
    end else if (bvalid_q && bready_i) begin
      bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_decerr ? DECERR : OKAY;
      rdata_q  <= rd_decerr ? '0 : rd_word;
    end else if (rvalid_q && rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = rvalid_q;
  assign rresp_o  = rresp_q;
  assign rdata_o  = rdata_q;
  assign reg_wr_o = reg_wr_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_q_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Self-checking bench for axi4l_reg_slave against an array-based register model.
module tb_axi4l_reg_slave;

  localparam int unsigned NR = 16;
  localparam logic [31:0] RV = 32'h5A5A_0F0F;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [31:0]   awaddr = '0, wdata = '0, araddr = '0;
  logic [2:0]    awprot = '0, arprot = '0;
  logic [3:0]    wstrb = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0] reg_wr;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [NR];

  axi4l_reg_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (NR),
    .RESET_VAL (RV)
  ) dut (
    .aclk_i   (aclk),
    .aresetn_i(aresetn),
    .awaddr_i (awaddr),
    .awprot_i (awprot),
    .awvalid_i(awvalid),
    .awready_o(awready),
    .wdata_i  (wdata),
    .wstrb_i  (wstrb),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .bresp_o  (bresp),
    .bvalid_o (bvalid),
    .bready_i (bready),
    .araddr_i (araddr),
    .arprot_i (arprot),
    .arvalid_i(arvalid),
    .arready_o(arready),
    .rdata_o  (rdata),
    .rresp_o  (rresp),
    .rvalid_o (rvalid),
    .rready_i (rready),
    .reg_q_o  (reg_q),
    .reg_wr_o (reg_wr)
  );

  always #5 aclk = ~aclk;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) model[i] = RV;
  endfunction

  // Full write transaction: AW offered at cycle awd, W at cycle wd, bready held low for hold cycles.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd, input int hold);
    int unsigned idx;
    logic aw_done, w_done, awh, wh;
    logic [1:0] exp_resp;
    logic [NR-1:0] exp_wr;
    int cyc;
    idx = addr >> 2;
    exp_resp = (idx < NR) ? 2'b00 : 2'b11;
    exp_wr = '0;
    if (idx < NR && strb != 4'b0000) exp_wr[idx] = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb; awprot = 3'($urandom);
    while (!(aw_done && w_done) && cyc < 30) begin
      awvalid = !aw_done && cyc >= awd;
      wvalid  = !w_done && cyc >= wd;
      awh = awvalid && awready;
      wh  = wvalid && wready;
      tick;
      cyc++;
      if (awh) aw_done = 1'b1;
      if (wh) w_done = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (!(aw_done && w_done)) begin
      failures++;
      $display("FAIL write_handshake_timeout: aw_done=%0b w_done=%0b required 1/1", aw_done, w_done);
      return;
    end
    if (idx < NR) begin
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
    end
    checks++;
    if (bvalid !== 1'b1) begin
      failures++; $display("FAIL write_bvalid_latency: bvalid=%b required 1", bvalid);
    end
    checks++;
    if (bresp !== exp_resp) begin
      failures++; $display("FAIL write_bresp: got %b required %b", bresp, exp_resp);
    end
    checks++;
    if (reg_wr !== exp_wr) begin
      failures++; $display("FAIL write_reg_wr_pulse: got %h required %h", reg_wr, exp_wr);
    end
    for (int h = 0; h < hold; h++) begin
      tick;
      checks++;
      if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0 || wready !== 1'b0) begin
        failures++;
        $display("FAIL write_b_hold: bvalid=%b bresp=%b awready=%b wready=%b required 1 %b 0 0",
                 bvalid, bresp, awready, wready, exp_resp);
      end
      checks++;
      if (reg_wr !== '0) begin
        failures++; $display("FAIL write_reg_wr_single: got %h required 0", reg_wr);
      end
    end
    checks++;
    if (awready !== 1'b0) begin
      failures++; $display("FAIL write_aw_blocked_before_b: awready=%b required 0", awready);
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || reg_wr !== '0) begin
      failures++;
      $display("FAIL write_after_b: bvalid=%b awready=%b wready=%b reg_wr=%h required 0 1 1 0",
               bvalid, awready, wready, reg_wr);
    end
    checks++;
    if (reg_q !== model_flat()) begin
      failures++; $display("FAIL write_reg_q: got %h required %h", reg_q, model_flat());
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold);
    int unsigned idx;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    logic done, arh;
    idx = addr >> 2;
    exp_data = (idx < NR) ? model[idx] : 32'h0;
    exp_resp = (idx < NR) ? 2'b00 : 2'b11;
    araddr = addr; arprot = 3'($urandom); arvalid = 1'b1; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      arh = arready;
      tick;
      if (arh) done = 1'b1;
    end
    arvalid = 1'b0;
    checks++;
    if (!done) begin
      failures++; $display("FAIL read_handshake_timeout: arready never seen, required within 20");
      return;
    end
    checks++;
    if (rvalid !== 1'b1) begin
      failures++; $display("FAIL read_rvalid_latency: rvalid=%b required 1", rvalid);
    end
    checks++;
    if (rdata !== exp_data || rresp !== exp_resp) begin
      failures++;
      $display("FAIL read_data: addr=%h got %h/%b required %h/%b", addr, rdata, rresp,
               exp_data, exp_resp);
    end
    for (int h = 0; h < hold; h++) begin
      tick;
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_data || arready !== 1'b0) begin
        failures++;
        $display("FAIL read_r_hold: rvalid=%b rdata=%h arready=%b required 1 %h 0",
                 rvalid, rdata, arready, exp_data);
      end
    end
    rready = 1'b1;
    checks++;
    if (arready !== 1'b0) begin
      failures++; $display("FAIL read_arready_in_r_hs: arready=%b required 0", arready);
    end
    tick;
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++; $display("FAIL read_after_r: rvalid=%b arready=%b required 0 1", rvalid, arready);
    end
  endtask

  task automatic test_reset;
    model_reset();
    aresetn = 1'b0;
    tick; tick;
    checks++;
    if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0 || bvalid !== 1'b0 ||
        rvalid !== 1'b0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== '0 || reg_wr !== '0) begin
      failures++;
      $display("FAIL reset_outputs: awr=%b wr=%b arr=%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h wr=%h required all 0",
               awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, reg_wr);
    end
    checks++;
    if (reg_q !== model_flat()) begin
      failures++; $display("FAIL reset_reg_q: got %h required %h", reg_q, model_flat());
    end
    aresetn = 1'b1;
    #1;
    checks++;
    if (arready !== 1'b0 || awready !== 1'b0) begin
      failures++; $display("FAIL reset_ready_early: arready=%b awready=%b required 0 0", arready, awready);
    end
    tick;
    checks++;
    if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_release: arr=%b awr=%b wr=%b required 1 1 1", arready, awready, wready);
    end
    do_read(32'h0C, 0);
  endtask

  task automatic test_directed_writes;
    do_write(32'h08, 32'hDEAD_BEEF, 4'b1111, 0, 2, 0);
    do_read(32'h08, 1);
    do_write(32'h04, 32'hAAAA_AAAA, 4'b1111, 0, 0, 0);
    do_write(32'h04, 32'h1122_3344, 4'b0101, 0, 0, 0);
    checks++;
    if (reg_q[1*32 +: 32] !== 32'hAA22_AA44) begin
      failures++; $display("FAIL strobe_merge: got %h required aa22aa44", reg_q[1*32 +: 32]);
    end
    do_write(32'h17, 32'h0102_0304, 4'b0000, 1, 0, 0);
    do_write(32'h3E, 32'hCAFE_F00D, 4'b1100, 2, 0, 0);
  endtask

  task automatic test_decerr;
    do_write(32'h40, 32'h1234_5678, 4'b1111, 0, 0, 0);
    do_read(32'h40, 0);
    do_read(32'h44, 1);
  endtask

  task automatic test_b_backpressure;
    do_write(32'h20, 32'h0BAD_F00D, 4'b1111, 0, 0, 5);
    do_write(32'h24, 32'h7777_8888, 4'b0011, 0, 0, 0);
  endtask

  task automatic test_same_edge;
    logic [31:0] old_val;
    old_val = model[5];
    awaddr = 32'h14; wdata = 32'h5555_6666; wstrb = 4'b1111; araddr = 32'h14;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_ready: awr=%b wr=%b arr=%b required 1 1 1", awready, wready, arready);
    end
    tick;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model[5] = 32'h5555_6666;
    checks++;
    if (rvalid !== 1'b1 || rdata !== old_val || bvalid !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_old_value: rvalid=%b rdata=%h bvalid=%b required 1 %h 1",
               rvalid, rdata, bvalid, old_val);
    end
    bready = 1'b1; rready = 1'b1;
    tick;
    bready = 1'b0; rready = 1'b0;
    do_read(32'h14, 0);
  endtask

  task automatic test_reset_mid_write;
    logic wh;
    wdata = 32'hFEED_FACE; wstrb = 4'b1111; wvalid = 1'b1;
    araddr = 32'h00; arvalid = 1'b1;
    wh = wready;
    tick;
    wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (!wh || wready !== 1'b0 || bvalid !== 1'b0 || rvalid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_setup: w_hs=%b wready=%b bvalid=%b rvalid=%b required 1 0 0 1",
               wh, wready, bvalid, rvalid);
    end
    tick;
    aresetn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_valids: bvalid=%b rvalid=%b awr=%b wr=%b required 0 0 0 0",
               bvalid, rvalid, awready, wready);
    end
    tick;
    aresetn = 1'b1;
    tick;
    awaddr = 32'h1C; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if (bvalid !== 1'b0 || reg_wr !== '0) begin
        failures++;
        $display("FAIL midreset_discard: bvalid=%b reg_wr=%h required 0 0", bvalid, reg_wr);
      end
    end
    checks++;
    if (reg_q !== model_flat()) begin
      failures++; $display("FAIL midreset_reg_q: got %h required %h", reg_q, model_flat());
    end
    aresetn = 1'b0;
    tick;
    aresetn = 1'b1;
    tick;
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = {25'h0, 7'($urandom_range(0, 8'h4F))};
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2));
      end else begin
        do_read(a, $urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_writes();
    test_decerr();
    test_b_backpressure();
    test_same_edge();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
